// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    localparam int unsigned UART_RX_OVS_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

endpackage : uart_rx_pkg

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: one tick every baud_div_i+1 clocks, held off while clear is high.
module uart_baud_tick_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             hit;

    // Compare against the live divisor so a new value applies at the next compare.
    assign hit    = (cnt_q >= baud_div_i);
    assign tick_o = ~clear & hit;

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clear || hit) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_tick_gen

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deserialiser with a one-byte valid/ready holding register.
// Optional UART_RX_FRAMING_ERR_EN adds framing_error_o and break handling.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned OVS    = UART_RX_OVS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic              rx_en_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              parity_error_o,
    output logic              overrun_o,
    output logic              busy_o,
`ifdef UART_RX_FRAMING_ERR_EN
    output logic              framing_error_o,
`endif
    output logic              free_o
);

    localparam int unsigned OVS_W = $clog2(OVS);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    logic [1:0]        sync_q;
    logic              rx_s;
    logic              tick;
    logic              mid;
    logic              deliver;
    logic              accept;

    uart_rx_state_e    state_q, state_d;
    logic [OVS_W-1:0]  ovs_q, ovs_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              pflag_q, pflag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;
    logic              free_q, free_d;
`ifdef UART_RX_FRAMING_ERR_EN
    logic              ferr_q, ferr_d;
    logic              brk_q, brk_d;
`endif

    assign rx_s = sync_q[1];
    assign mid  = tick & (ovs_q == OVS_W'(OVS / 2 - 1));

    uart_baud_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == IDLE),
        .baud_div_i (baud_div_i),
        .tick_o     (tick)
    );

    always_comb begin
        state_d = state_q;
        ovs_d   = ovs_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pflag_d = pflag_q;
        deliver = 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
        ferr_d  = 1'b0;
        brk_d   = brk_q;
`endif

        if (tick) begin
            ovs_d = ovs_q + OVS_W'(1);
        end

        if (!rx_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    ovs_d = '0;
`ifdef UART_RX_FRAMING_ERR_EN
                    if (rx_s) begin
                        brk_d = 1'b0;
                    end
                    if (!rx_s && !brk_q) begin
                        state_d = START;
                    end
`else
                    if (!rx_s) begin
                        state_d = START;
                    end
`endif
                end
                START: begin
                    if (mid) begin
                        bit_d   = '0;
                        pflag_d = 1'b0;
                        state_d = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift_d = {rx_s, shift_q[DATA_W-1:1]};
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            state_d = parity_en_i ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (mid) begin
                        pflag_d = (^shift_q) ^ rx_s ^ parity_odd_i;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        state_d = IDLE;
`ifdef UART_RX_FRAMING_ERR_EN
                        // A low stop bit is treated as a break: drop the frame and wait for idle.
                        if (rx_s) begin
                            deliver = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                            brk_d  = 1'b1;
                        end
`else
                        deliver = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register: load, accept, or overrun-drop the completed byte.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ovr_d   = 1'b0;
        accept  = valid_q & data_ready_i;

        if (accept) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (valid_q && !data_ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = pflag_q;
            end
        end

        busy_d = (state_d != IDLE);
        free_d = (state_d == IDLE) & ~valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            ovs_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pflag_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            free_q  <= 1'b1;
`ifdef UART_RX_FRAMING_ERR_EN
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            ovs_q   <= ovs_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pflag_q <= pflag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
            free_q  <= free_d;
`ifdef UART_RX_FRAMING_ERR_EN
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
`endif
        end
    end

    assign data_o         = data_q;
    assign data_valid_o   = valid_q;
    assign parity_error_o = perr_q;
    assign overrun_o      = ovr_q;
    assign busy_o         = busy_q;
    assign free_o         = free_q;
`ifdef UART_RX_FRAMING_ERR_EN
    assign framing_error_o = ferr_q;
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are driven, expected bytes queued and checked on transfer.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic        rx_i;
    logic [15:0] baud_div_i;
    logic        rx_en_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        parity_error_o;
    logic        overrun_o;
    logic        busy_o;
    logic        free_o;
`ifdef UART_RX_FRAMING_ERR_EN
    logic        framing_error_o;
`endif

    int          n_checks;
    int          n_errors;
    int          valid_cycles;
    int          perr_cnt;
    int          ovr_cnt;
    int          ferr_cnt;
    logic [7:0]  sb_q[$];

    uart_rx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_i           (rx_i),
        .baud_div_i     (baud_div_i),
        .rx_en_i        (rx_en_i),
        .parity_en_i    (parity_en_i),
        .parity_odd_i   (parity_odd_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .parity_error_o (parity_error_o),
        .overrun_o      (overrun_o),
        .busy_o         (busy_o),
`ifdef UART_RX_FRAMING_ERR_EN
        .framing_error_o(framing_error_o),
`endif
        .free_o         (free_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pulse counters and scoreboard pop on each handshake transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid_o) valid_cycles++;
            if (overrun_o) ovr_cnt++;
            if (parity_error_o) begin
                perr_cnt++;
                check("perr_with_valid", 32'(data_valid_o), 32'd1);
            end
`ifdef UART_RX_FRAMING_ERR_EN
            if (framing_error_o) ferr_cnt++;
`endif
            if (data_valid_o && data_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_byte", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    check("data", 32'(data_o), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    function automatic int bit_clks();
        return (int'(baud_div_i) + 1) * 16;
    endfunction

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (bit_clks()) @(negedge clk);
    endtask

    task automatic frame_bits(input logic [7:0] b, input logic par_en, input logic par_bit,
                              input logic stop_bit);
        drive_bit(1'b0);
        check("busy_in_frame", 32'(busy_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
        end
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_en, input logic par_bit);
        frame_bits(b, par_en, par_bit, 1'b1);
        rx_i = 1'b1;
        repeat (2 * bit_clks()) @(negedge clk);
        check("busy_after_frame", 32'(busy_o), 32'd0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 data_ready_i = v;
    endtask

    initial begin
        int v0, p0, o0;
        n_checks     = 0;
        n_errors     = 0;
        valid_cycles = 0;
        perr_cnt     = 0;
        ovr_cnt      = 0;
        ferr_cnt     = 0;
        rst_n        = 1'b0;
        rx_i         = 1'b1;
        baud_div_i   = 16'd0;
        rx_en_i      = 1'b1;
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        data_ready_i = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(data_valid_o), 32'd0);
        check("rst_free", 32'(free_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_perr", 32'(parity_error_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain 8N1 frame, consumer always ready.
        v0 = valid_cycles;
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0);
        check("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("a5_free", 32'(free_o), 32'd1);

        // Even parity: wrong parity bit flags error, correct one does not.
        parity_en_i = 1'b1;
        parity_odd_i = 1'b0;
        p0 = perr_cnt;
        sb_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b1);
        check("par_bad_pulse", 32'(perr_cnt - p0), 32'd1);
        sb_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        check("par_good_nopulse", 32'(perr_cnt - p0), 32'd1);
        // Odd parity with a correct bit.
        parity_odd_i = 1'b1;
        sb_q.push_back(8'hC4);
        send_frame(8'hC4, 1'b1, 1'b0);
        check("par_odd_nopulse", 32'(perr_cnt - p0), 32'd1);
        parity_en_i = 1'b0;
        parity_odd_i = 1'b0;

        // Overrun: second frame dropped while first is unconsumed.
        set_ready(1'b0);
        o0 = ovr_cnt;
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0);
        check("ovr_first_held", 32'(data_o), 32'h11);
        check("ovr_free_low", 32'(free_o), 32'd0);
        send_frame(8'h22, 1'b0, 1'b0);
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_data_kept", 32'(data_o), 32'h11);
        check("ovr_valid_kept", 32'(data_valid_o), 32'd1);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check("ovr_drain_valid", 32'(data_valid_o), 32'd0);
        check("ovr_drain_free", 32'(free_o), 32'd1);

        // Start-bit glitch at baud_div_i=1 must be rejected.
        baud_div_i = 16'd1;
        v0 = valid_cycles;
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_idle", 32'(busy_o), 32'd0);
        check("glitch_novalid", 32'(valid_cycles - v0), 32'd0);
        check("glitch_free", 32'(free_o), 32'd1);

        // Slower baud frame after the glitch.
        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0);

        // Receiver disabled mid-frame drops the partial byte.
        v0 = valid_cycles;
        rx_i = 1'b0;
        repeat (bit_clks() * 3) @(negedge clk);
        rx_en_i = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_busy", 32'(busy_o), 32'd0);
        rx_i = 1'b1;
        repeat (bit_clks() * 8) @(negedge clk);
        rx_en_i = 1'b1;
        repeat (2) @(negedge clk);
        check("dis_novalid", 32'(valid_cycles - v0), 32'd0);
        baud_div_i = 16'd0;

`ifdef UART_RX_FRAMING_ERR_EN
        // Stop bit low: framing error, frame dropped, break held until line idles.
        v0 = valid_cycles;
        frame_bits(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (3 * bit_clks()) @(negedge clk);
        check("ferr_pulse", 32'(ferr_cnt), 32'd1);
        check("ferr_novalid", 32'(valid_cycles - v0), 32'd0);
        check("ferr_break_idle", 32'(busy_o), 32'd0);
        rx_i = 1'b1;
        repeat (bit_clks()) @(negedge clk);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("ferr_recover", 32'(valid_cycles - v0), 32'd1);
`endif

        repeat (10) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("final_perr_total", 32'(perr_cnt), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_rx
